// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the Mini SRC datapath.
// Drives every datapath control line from the step counter, the IR opcode, CON FF and the memory handshake.
module control_sequencer #(
    parameter logic [4:0]  ADD_OP     = 5'b00011,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
    output logic [4:0]  alu_op,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        run,
    output logic        fault
);

    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam logic [4:0]  OP_LD   = 5'd0;
    localparam logic [4:0]  OP_LDI  = 5'd1;
    localparam logic [4:0]  OP_ST   = 5'd2;
    localparam logic [31:0] LIMIT   = 32'(WAIT_LIMIT);

    state_t      state, state_next;
    logic [31:0] wait_cnt;
    logic        in_wait, set_fault, timeout;
    logic [4:0]  opcode;
    logic        unused_ir_bits;

    assign opcode         = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];
    // This unanswered cycle is the LIMIT-th one spent in the current wait state.
    assign timeout        = (LIMIT != 32'd0) && (wait_cnt + 32'd1 >= LIMIT);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= RST;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 32'd1;
            if (set_fault)
                fault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        in_wait    = 1'b0;
        set_fault  = 1'b0;
        alu_op     = '0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; Yin = 1'b0; Zin = 1'b0; PCin = 1'b0; IRin = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; CONin = 1'b0; OutPortin = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; PCout = 1'b0;
        MDRout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        Read = 1'b0; Write = 1'b0; IncPC = 1'b0;
        run = (state != RST) && (state != HALT);

        case (state)
            RST: state_next = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_next = T1;
            end
            T1: begin
                Zlowout = 1'b1; Read = 1'b1; in_wait = 1'b1;
                if (mem_ready) begin
                    PCin = 1'b1; MDRin = 1'b1; state_next = T2;
                end else if (timeout) begin
                    set_fault = 1'b1; state_next = HALT;
                end
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_next = stop ? HALT : T3;
            end
            HALT: ;
            default: begin
                // Execute steps; falling out of a step without naming a successor ends the instruction.
                state_next = T0;
                case (opcode) inside
                    [5'd3:5'd14]: case (state)
                        T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_next = T4; end
                        T4: begin
                            if (opcode >= 5'd12) Cout = 1'b1;
                            else begin Grc = 1'b1; Rout = 1'b1; end
                            Zin = 1'b1; alu_op = opcode; state_next = T5;
                        end
                        T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                    5'd15, 5'd16: case (state)
                        T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; state_next = T4; end
                        T4: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; state_next = T5; end
                        T5: begin Zlowout = 1'b1; LOin = 1'b1; state_next = T6; end
                        T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                        default: ;
                    endcase
                    5'd17, 5'd18: case (state)
                        T3: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; state_next = T4; end
                        T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                    OP_LD, OP_LDI, OP_ST: case (state)
                        T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_next = T4; end
                        T4: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; state_next = T5; end
                        T5: begin
                            Zlowout = 1'b1;
                            if (opcode == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                            else begin MARin = 1'b1; state_next = T6; end
                        end
                        T6: begin
                            if (opcode == OP_LD) begin
                                Read = 1'b1; in_wait = 1'b1;
                                if (mem_ready) begin MDRin = 1'b1; state_next = T7; end
                                else if (timeout) begin set_fault = 1'b1; state_next = HALT; end
                                else state_next = T6;
                            end else if (opcode == OP_ST) begin
                                Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_next = T7;
                            end
                        end
                        T7: begin
                            if (opcode == OP_LD) begin
                                MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            end else if (opcode == OP_ST) begin
                                Write = 1'b1; in_wait = 1'b1;
                                if (mem_ready) state_next = T0;
                                else if (timeout) begin set_fault = 1'b1; state_next = HALT; end
                                else state_next = T7;
                            end
                        end
                        default: ;
                    endcase
                    5'd19: case (state)
                        T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_next = T4; end
                        T4: begin PCout = 1'b1; Yin = 1'b1; state_next = T5; end
                        T5: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; state_next = T6; end
                        T6: begin Zlowout = 1'b1; PCin = con_ff; end
                        default: ;
                    endcase
                    5'd20: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    5'd22: begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    5'd23: begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    5'd24: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    5'd25: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    5'd27: state_next = HALT;
                    default: ;
                endcase
            end
        endcase
    end

endmodule
